// File: rtl/axi_stream_pkg.sv
// Shared types and helpers for the AXI-stream header stripper.
package axi_stream_pkg;

    localparam int unsigned DEF_DATA_WD = 32;
    localparam int unsigned MAX_BYTE_WD = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRST,
        ST_PASS,
        ST_TAIL
    } strip_state_e;

    function automatic int unsigned keep_to_cnt(input logic [MAX_BYTE_WD-1:0] keep);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < MAX_BYTE_WD; i++) begin
            cnt += 32'(keep[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axi_keep_cnt.sv
// Keep-mask helper: byte count of a keep vector, and MSB-aligned keep from a count.
module axi_keep_cnt
    import axi_stream_pkg::*;
#(
    parameter int unsigned BYTE_WD = 4,
    parameter int unsigned CNT_WD  = $clog2(BYTE_WD) + 1
) (
    input  logic [BYTE_WD-1:0] keep_i,
    output logic [CNT_WD-1:0]  cnt_o,
    input  logic [CNT_WD-1:0]  cnt_i,
    output logic [BYTE_WD-1:0] keep_o
);

    always_comb begin
        cnt_o = CNT_WD'(keep_to_cnt(MAX_BYTE_WD'(keep_i)));
    end

    always_comb begin
        keep_o = '0;
        for (int unsigned i = 0; i < BYTE_WD; i++) begin
            if (i < 32'(cnt_i)) begin
                keep_o[BYTE_WD-1-i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_stream_strip_header.sv
// Removes S leading bytes from each packet and realigns the remaining stream,
// holding the shifted-out remainder of each beat in a residual buffer.
module axi_stream_strip_header
    import axi_stream_pkg::*;
#(
    parameter int unsigned DATA_WD      = DEF_DATA_WD,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_strip,
    input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
    output logic                    ready_strip
);

    localparam int unsigned        CNT_WD   = BYTE_CNT_WD + 1;
    localparam logic [CNT_WD-1:0]  FULL_CNT = CNT_WD'(DATA_BYTE_WD);

    strip_state_e state_q, state_d;

    logic [BYTE_CNT_WD-1:0]  strip_q, strip_d;
    logic [DATA_WD-1:0]      buf_q, buf_d;
    logic [CNT_WD-1:0]       res_q, res_d;

    logic                    out_valid_q, out_valid_d;
    logic [DATA_WD-1:0]      out_data_q, out_data_d;
    logic [DATA_BYTE_WD-1:0] out_keep_q, out_keep_d;
    logic                    out_last_q, out_last_d;

    logic                    can_load;
    logic                    acc_in;
    logic                    acc_strip;
    logic [DATA_WD-1:0]      data_m;
    logic [DATA_WD-1:0]      data_shl;
    logic [DATA_WD-1:0]      data_shr;
    logic [CNT_WD-1:0]       n_in;
    logic [CNT_WD-1:0]       s_ext;
    logic [CNT_WD-1:0]       n_rem;
    logic [CNT_WD-1:0]       n_take;
    logic [CNT_WD-1:0]       pass_cnt;
    logic [CNT_WD-1:0]       keep_cnt_sel;
    logic [DATA_BYTE_WD-1:0] keep_from_cnt;

    assign can_load    = !out_valid_q || ready_out;
    assign ready_strip = (state_q == ST_IDLE);
    assign ready_in    = ((state_q == ST_FIRST) || (state_q == ST_PASS)) && can_load;
    assign acc_in      = valid_in && ready_in;
    assign acc_strip   = valid_strip && ready_strip;

    assign valid_out = out_valid_q;
    assign data_out  = out_data_q;
    assign keep_out  = out_keep_q;
    assign last_out  = out_last_q;

    assign s_ext        = CNT_WD'(strip_q);
    assign n_rem        = (n_in > s_ext) ? (n_in - s_ext) : '0;
    assign n_take       = (n_in < s_ext) ? n_in : s_ext;
    assign pass_cnt     = FULL_CNT - s_ext + n_take;
    assign keep_cnt_sel = (state_q == ST_TAIL) ? res_q : pass_cnt;

    // Zero invalid input lanes so shifted bytes never leak into data_out.
    always_comb begin
        data_m = '0;
        for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
            if (keep_in[i]) begin
                data_m[8*i +: 8] = data_in[8*i +: 8];
            end
        end
    end

    assign data_shl = data_m << (32'd8 * 32'(strip_q));
    assign data_shr = data_m >> (32'd8 * (DATA_BYTE_WD - 32'(strip_q)));

    axi_keep_cnt #(
        .BYTE_WD (DATA_BYTE_WD),
        .CNT_WD  (CNT_WD)
    ) u_keep_cnt (
        .keep_i (keep_in),
        .cnt_o  (n_in),
        .cnt_i  (keep_cnt_sel),
        .keep_o (keep_from_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (acc_strip) begin
                    state_d = ST_FIRST;
                end
            end
            ST_FIRST: begin
                if (acc_in) begin
                    if (!last_in) begin
                        state_d = ST_PASS;
                    end else if (n_rem != '0) begin
                        state_d = ST_TAIL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_PASS: begin
                if (acc_in && last_in) begin
                    state_d = (n_rem != '0) ? ST_TAIL : ST_IDLE;
                end
            end
            ST_TAIL: begin
                if (can_load) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        strip_d     = strip_q;
        buf_d       = buf_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;

        if (acc_strip) begin
            strip_d = byte_strip_cnt;
        end

        if (can_load) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_keep_d  = '0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            ST_FIRST: begin
                if (acc_in) begin
                    buf_d = data_shl;
                    res_d = n_rem;
                end
            end
            ST_PASS: begin
                // Buffer holds exactly DATA_BYTE_WD-S bytes here, low S lanes zero.
                if (acc_in) begin
                    out_valid_d = 1'b1;
                    out_data_d  = buf_q | data_shr;
                    out_keep_d  = keep_from_cnt;
                    out_last_d  = last_in && (n_rem == '0);
                    buf_d       = data_shl;
                    res_d       = n_rem;
                end
            end
            ST_TAIL: begin
                if (can_load) begin
                    out_valid_d = 1'b1;
                    out_data_d  = buf_q;
                    out_keep_d  = keep_from_cnt;
                    out_last_d  = 1'b1;
                    buf_d       = '0;
                    res_d       = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            strip_q     <= '0;
            buf_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            strip_q     <= strip_d;
            buf_q       <= buf_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Directed bench for axi_stream_strip_header: packet table plus stall and reset sequences.
module tb_axi_stream_strip_header;

    localparam int BOUND = 40;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out;
    logic        valid_strip;
    logic [1:0]  byte_strip_cnt;
    logic        ready_strip;

    axi_stream_strip_header #(
        .DATA_WD (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .data_in        (data_in),
        .keep_in        (keep_in),
        .last_in        (last_in),
        .ready_in       (ready_in),
        .valid_out      (valid_out),
        .data_out       (data_out),
        .keep_out       (keep_out),
        .last_out       (last_out),
        .ready_out      (ready_out),
        .valid_strip    (valid_strip),
        .byte_strip_cnt (byte_strip_cnt),
        .ready_strip    (ready_strip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]         s;
        logic [2:0]         nin;
        logic [0:3][31:0]   din;
        logic [0:3][3:0]    kin;
        logic [2:0]         nout;
        logic [0:3][31:0]   dout;
        logic [0:3][3:0]    kout;
    } vec_t;

    vec_t        vecs [9];
    logic [36:0] cap_q [$];
    int          vectors;
    int          miscompares;
    int          w;

    always @(negedge clk) begin
        if (!rst && valid_out && ready_out) begin
            cap_q.push_back({data_out, keep_out, last_out});
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic note_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound of %0d cycles expired", name, BOUND);
    endtask

    task automatic send_pkt(input vec_t v, output int waits);
        int cyc;
        waits = 0;
        @(posedge clk); #1;
        valid_strip    = 1'b1;
        byte_strip_cnt = v.s;
        cyc = 0;
        while (1'b1) begin
            @(negedge clk);
            if (ready_strip) break;
            cyc++;
            if (cyc > BOUND) begin
                note_fail("strip_timeout");
                break;
            end
        end
        @(posedge clk); #1;
        valid_strip = 1'b0;
        for (int i = 0; i < int'(v.nin); i++) begin
            valid_in = 1'b1;
            data_in  = v.din[i];
            keep_in  = v.kin[i];
            last_in  = (i == int'(v.nin) - 1);
            cyc = 0;
            while (1'b1) begin
                @(negedge clk);
                if (ready_in) break;
                cyc++;
                waits++;
                if (cyc > BOUND) begin
                    note_fail("beat_timeout");
                    break;
                end
            end
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
        data_in  = '0;
        keep_in  = '0;
    endtask

    task automatic check_pkt(input int idx);
        vec_t v;
        logic lastx;
        v = vecs[idx];
        check($sformatf("v%0d_nbeats", idx), 64'(cap_q.size()), 64'(v.nout));
        for (int j = 0; j < int'(v.nout); j++) begin
            if (j < cap_q.size()) begin
                lastx = (j == int'(v.nout) - 1);
                check($sformatf("v%0d_beat%0d", idx, j), 64'(cap_q[j]),
                      64'({v.dout[j], v.kout[j], lastx}));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int found;
        vectors        = 0;
        miscompares    = 0;
        rst            = 1'b1;
        valid_in       = 1'b0;
        data_in        = '0;
        keep_in        = '0;
        last_in        = 1'b0;
        ready_out      = 1'b1;
        valid_strip    = 1'b0;
        byte_strip_cnt = '0;

        vecs[0] = '{s: 2'd1, nin: 3'd3,
                    din: {32'hAABBCCDD, 32'hEEFF0011, 32'h22334400, 32'h0}, kin: {4'hF, 4'hF, 4'hE, 4'h0},
                    nout: 3'd3,
                    dout: {32'hBBCCDDEE, 32'hFF001122, 32'h33440000, 32'h0}, kout: {4'hF, 4'hF, 4'hC, 4'h0}};
        vecs[1] = '{s: 2'd0, nin: 3'd2,
                    din: {32'h11223344, 32'h55000000, 32'h0, 32'h0}, kin: {4'hF, 4'h8, 4'h0, 4'h0},
                    nout: 3'd2,
                    dout: {32'h11223344, 32'h55000000, 32'h0, 32'h0}, kout: {4'hF, 4'h8, 4'h0, 4'h0}};
        vecs[2] = '{s: 2'd2, nin: 3'd2,
                    din: {32'hAABBCCDD, 32'hEEFF0000, 32'h0, 32'h0}, kin: {4'hF, 4'hC, 4'h0, 4'h0},
                    nout: 3'd1,
                    dout: {32'hCCDDEEFF, 32'h0, 32'h0, 32'h0}, kout: {4'hF, 4'h0, 4'h0, 4'h0}};
        vecs[3] = '{s: 2'd3, nin: 3'd1,
                    din: {32'hAABB0000, 32'h0, 32'h0, 32'h0}, kin: {4'hC, 4'h0, 4'h0, 4'h0},
                    nout: 3'd0,
                    dout: {32'h0, 32'h0, 32'h0, 32'h0}, kout: {4'h0, 4'h0, 4'h0, 4'h0}};
        vecs[4] = '{s: 2'd2, nin: 3'd1,
                    din: {32'hAABBCCDD, 32'h0, 32'h0, 32'h0}, kin: {4'hF, 4'h0, 4'h0, 4'h0},
                    nout: 3'd1,
                    dout: {32'hCCDD0000, 32'h0, 32'h0, 32'h0}, kout: {4'hC, 4'h0, 4'h0, 4'h0}};
        vecs[5] = '{s: 2'd3, nin: 3'd2,
                    din: {32'h11223344, 32'h55667788, 32'h0, 32'h0}, kin: {4'hF, 4'hF, 4'h0, 4'h0},
                    nout: 3'd2,
                    dout: {32'h44556677, 32'h88000000, 32'h0, 32'h0}, kout: {4'hF, 4'h8, 4'h0, 4'h0}};
        vecs[6] = '{s: 2'd1, nin: 3'd2,
                    din: {32'h11223344, 32'h55000000, 32'h0, 32'h0}, kin: {4'hF, 4'h8, 4'h0, 4'h0},
                    nout: 3'd1,
                    dout: {32'h22334455, 32'h0, 32'h0, 32'h0}, kout: {4'hF, 4'h0, 4'h0, 4'h0}};
        vecs[7] = '{s: 2'd3, nin: 3'd2,
                    din: {32'h11223344, 32'h55660000, 32'h0, 32'h0}, kin: {4'hF, 4'hC, 4'h0, 4'h0},
                    nout: 3'd1,
                    dout: {32'h44556600, 32'h0, 32'h0, 32'h0}, kout: {4'hE, 4'h0, 4'h0, 4'h0}};
        // Garbage in the dropped lanes of the last beat must not reach data_out.
        vecs[8] = '{s: 2'd1, nin: 3'd2,
                    din: {32'h11223344, 32'h55667788, 32'h0, 32'h0}, kin: {4'hF, 4'h8, 4'h0, 4'h0},
                    nout: 3'd1,
                    dout: {32'h22334455, 32'h0, 32'h0, 32'h0}, kout: {4'hF, 4'h0, 4'h0, 4'h0}};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_last_out", 64'(last_out), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_keep_out", 64'(keep_out), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready_in", 64'(ready_in), 64'd0);
        check("idle_ready_strip", 64'(ready_strip), 64'd1);

        for (int i = 0; i < 9; i++) begin
            cap_q.delete();
            send_pkt(vecs[i], w);
            check($sformatf("v%0d_throughput_waits", i), 64'(w), 64'd0);
            repeat (6) @(posedge clk);
            check_pkt(i);
        end

        // Short packet: nothing emitted and command port reopens quickly.
        cap_q.delete();
        send_pkt(vecs[3], w);
        found = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (ready_strip) found = 1;
        end
        check("short_ready_strip", 64'(found), 64'd1);
        repeat (4) @(posedge clk);
        check("short_no_output", 64'(cap_q.size()), 64'd0);

        // Downstream stall while the first realigned beat is pending.
        cap_q.delete();
        @(posedge clk); #1;
        ready_out = 1'b0;
        fork
            send_pkt(vecs[0], w);
            begin
                int cyc;
                cyc = 0;
                while (1'b1) begin
                    @(negedge clk);
                    if (valid_out) break;
                    cyc++;
                    if (cyc > BOUND) begin
                        note_fail("stall_valid_timeout");
                        break;
                    end
                end
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    check($sformatf("stall_hold%0d", k),
                          64'({valid_out, ready_in, data_out, keep_out, last_out}),
                          64'({1'b1, 1'b0, 32'hBBCCDDEE, 4'hF, 1'b0}));
                end
                @(posedge clk); #1;
                ready_out = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        check_pkt(0);

        // Reset asserted while the second beat is presented.
        cap_q.delete();
        @(posedge clk); #1;
        valid_strip    = 1'b1;
        byte_strip_cnt = 2'd1;
        @(negedge clk);
        check("rstmid_cmd_ready", 64'(ready_strip), 64'd1);
        @(posedge clk); #1;
        valid_strip = 1'b0;
        valid_in    = 1'b1;
        data_in     = 32'hAABBCCDD;
        keep_in     = 4'hF;
        last_in     = 1'b0;
        @(posedge clk); #1;
        data_in = 32'hEEFF0011;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        keep_in  = '0;
        @(negedge clk);
        check("rstmid_valid_out", 64'(valid_out), 64'd0);
        check("rstmid_ready_strip", 64'(ready_strip), 64'd1);
        repeat (3) @(posedge clk);
        check("rstmid_no_output", 64'(cap_q.size()), 64'd0);
        cap_q.delete();
        send_pkt(vecs[0], w);
        repeat (6) @(posedge clk);
        check_pkt(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_stream_strip_header.md
AXI_STREAM_STRIP_HEADER -- requirements
Module: axi_stream_strip_header

Interface
REQ-001 Parameter DATA_WD, 32, stream data width in bits (multiple of 8).
REQ-002 Parameter DATA_BYTE_WD, DATA_WD/8, bytes per beat.
REQ-003 Parameter BYTE_CNT_WD, $clog2(DATA_BYTE_WD), strip count width.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 valid_in / data_in / keep_in / last_in  in  1/DATA_WD/DATA_BYTE_WD/1  upstream beat; keep MSB-aligned contiguous, byte 0 = data_in[DATA_WD-1:DATA_WD-8].
REQ-007 ready_in  out  1  upstream beat accepted when valid_in & ready_in.
REQ-008 valid_out / data_out / keep_out / last_out  out  1/DATA_WD/DATA_BYTE_WD/1  realigned downstream beat, same byte/keep convention.
REQ-009 ready_out  in  1  downstream acceptance.
REQ-010 valid_strip / byte_strip_cnt / ready_strip  in/in/out  1/BYTE_CNT_WD/1  per-packet strip command, S = byte_strip_cnt leading bytes (0..DATA_BYTE_WD-1) removed.

Function
REQ-011 States IDLE, FIRST, PASS, TAIL; reset state IDLE.
REQ-012 ready_strip SHALL be 1 only in IDLE; command handshake latches S, IDLE->FIRST.
REQ-013 ready_in SHALL be 1 only in FIRST/PASS and when output register is empty or ready_out=1.
REQ-014 n_in = popcount(keep_in); residual buffer holds up to DATA_BYTE_WD left-aligned bytes plus count R.
REQ-015 FIRST accept: buffer = data_in << 8*S, R = max(n_in-S,0), no output; if !last_in -> PASS; if last_in & R>0 -> TAIL; if last_in & R=0 -> IDLE, packet emits nothing.
REQ-016 PASS accept: output beat = top (DATA_BYTE_WD-S) buffer bytes concatenated with top S bytes of data_in, keep count = (DATA_BYTE_WD-S)+min(S,n_in); new R = max(n_in-S,0), buffer = data_in << 8*S.
REQ-017 PASS accept with last_in: if new R=0, that output beat carries last_out=1 and -> IDLE; else -> TAIL.
REQ-018 TAIL: emit buffer with keep of R MSB ones, last_out=1, on handshake -> IDLE.
REQ-019 Output register: valid_out/data_out/keep_out/last_out change only when empty or ready_out=1; held stable while valid_out & !ready_out.
REQ-020 Latency: one input beat (output for beat k issued registered after beat k+1 accepted or TAIL); full throughput with ready_out=1.
REQ-021 S=0 SHALL pass data unchanged with one-beat latency.
REQ-022 Invalid byte lanes of data_out SHALL be zero.
REQ-023 Packet bytes <= S SHALL produce no output beat.

Reset
REQ-024 rst SHALL clear at the next edge: valid_out=0, last_out=0, data_out=0, keep_out=0, buffer and R=0, state=IDLE (ready_in=0, ready_strip=1 after release).
REQ-025 rst mid-packet SHALL discard all buffered and in-flight bytes with no partial beat emitted.

Structure
REQ-026 Shared package axi_stream_pkg SHALL hold state enum, default widths and keep-to-count function.
REQ-027 One sub-module axi_keep_cnt (keep -> byte count, MSB-aligned keep from count) SHALL be used.

Verification (DATA_WD=32)
REQ-028 S=1, beats AABBCCDD/1111, EEFF0011/1111, 22334400/1110 last -> BBCCDDEE/1111, FF001122/1111, 33440000/1100 last.
REQ-029 S=0, beats 11223344/1111, 55000000/1000 last -> identical beats out, one-beat latency.
REQ-030 S=2, beats AABBCCDD/1111, EEFF0000/1100 last -> single CCDDEEFF/1111 last, no TAIL.
REQ-031 S=3, single beat AABB0000/1100 last -> no valid_out, ready_strip=1 within 2 cycles.
REQ-032 ready_out=0 for 5 cycles mid-packet -> output signals stable, ready_in=0, no byte lost/duplicated.
REQ-033 rst pulsed during beat 2 -> next edge valid_out=0, ready_strip=1; following packet output correct.
